lsu_align: RTL and testbench
============================

LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter: SPLIT_EN, default 1, 1 = misaligned accesses split into two word accesses, 0 = misaligned accesses rejected with rsp_err.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  block accepts request; transfer on the rising edge with req_valid=1 and req_ready=1.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  qualified by rsp_valid; illegal funct3 or rejected misaligned access.
REQ-013 daddr  output  32  word-aligned memory address (bits [1:0] always 00).
REQ-014 dwdata  output  32  memory write data, lane-placed.
REQ-015 dwe  output  4  per-byte write enables; lane k = dwdata[8k+7:8k].
REQ-016 drdata  input  32  memory read data, combinational from daddr.

Function
REQ-017 States: IDLE, ACC0, ACC1, DONE; req_ready=1 only in IDLE.
REQ-018 IDLE: on handshake, latch we/funct3/addr/wdata, go ACC0; otherwise stay.
REQ-019 Size n = 1/2/4 from funct3[1:0]; offset o = addr[1:0]; crossing when o+n > 4.
REQ-020 Illegal: funct3 in {011,110,111} for loads, funct3 not in {000,001,010} for stores; also crossing when SPLIT_EN=0; illegal requests go IDLE->ACC0->DONE with dwe=0 throughout, rsp_err=1.
REQ-021 ACC0: daddr={addr[31:2],2'b00}; dwe lanes o..min(o+n,4)-1 for legal stores, else 0; drdata captured into low buffer word at exit edge.
REQ-022 ACC0 -> ACC1 if legal and crossing, else -> DONE.
REQ-023 ACC1: daddr={addr[31:2],2'b00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); dwe lanes 0..o+n-5 for stores; drdata captured into high buffer word; -> DONE.
REQ-024 dwdata = req_wdata rotated left by 8*o in both ACC states; don't-care when dwe=0.
REQ-025 Load result = ({high,low} >> 8*o) truncated to n bytes, sign-extended for B/H, zero-extended for BU/HU.
REQ-026 DONE: rsp_valid=1, rsp_rdata and rsp_err valid for that cycle only; -> IDLE.
REQ-027 Latency from accepting edge to rsp_valid: 2 cycles non-crossing/illegal, 3 cycles crossing; back-to-back throughput one request per 3 (or 4) cycles.
REQ-028 dwe is nonzero only in ACC0/ACC1; memory write commits at the edge leaving that state; at most one write per lane per word.
REQ-029 Store byte lanes outside the access are never enabled; loads never assert dwe.

Reset
REQ-030 rst_n low forces IDLE immediately, regardless of clock or state, aborting any in-flight request with no response.
REQ-031 During and after reset: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dwe=0, daddr=0, dwdata=0, capture buffers=0.
REQ-032 A store aborted by reset in ACC1 leaves its ACC0 bytes written; no retry.

Verification
REQ-033 SW addr 0x100 data 0xDEADBEEF -> one ACC cycle, daddr 0x100, dwe 1111, dwdata 0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err 0.
REQ-034 Memory words 0x200=0x44332211, 0x204=0x88776655; LW addr 0x203 -> daddr 0x200 then 0x204, rsp_rdata 0x77665544; LH 0x203 -> 0x00005544; LB 0x204 -> 0x00000055; LB 0x207 -> 0xFFFFFF88; LBU 0x207 -> 0x00000088.
REQ-035 SH addr 0x1FF data 0x0000CAFE -> ACC0 daddr 0x1FC dwe 1000 lane3=0xFE, ACC1 daddr 0x200 dwe 0001 lane0=0xCA; readback LHU 0x1FF = 0x0000CAFE.
REQ-036 SW addr 0xFFFFFFFE -> second access daddr 0x00000000 dwe 0011; SPLIT_EN=0 same request -> dwe 0 both cycles, rsp_err 1, rsp_rdata 0.
REQ-037 Load funct3 011 -> rsp_err 1 after 2 cycles; store funct3 100 -> rsp_err 1, no write.
REQ-038 rst_n low during ACC1 of a crossing store -> dwe 0 immediately, no rsp_valid, req_ready 1; next request completes normally.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align: RV32 load/store alignment unit.
// Turns one byte/half/word request into one or two word-aligned memory
// accesses, places store bytes on the right lanes, and extracts and
// extends load data. Misaligned accesses that cross a word boundary are
// split into two accesses (SPLIT_EN=1) or rejected with rsp_err (SPLIT_EN=0).
module lsu_align #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] buf_lo;
    logic [31:0] buf_hi;

    logic [1:0]  offset;
    logic [2:0]  size;
    logic [3:0]  size_mask;
    logic [2:0]  end_pos;
    logic        crossing;
    logic        funct3_bad;
    logic        illegal;
    logic [7:0]  span;
    logic [63:0] wdata_pair;
    logic [5:0]  rot_base;
    logic [31:0] wdata_rot;
    logic [63:0] rdata_pair;
    logic [31:0] load_word;
    logic [31:0] load_ext;
    logic [31:0] word_addr;

    assign offset    = r_addr[1:0];
    assign word_addr = {r_addr[31:2], 2'b00};

    // Decode access size and legality of the latched request.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        size      = 3'd4;
        size_mask = 4'b1111;
        case (r_funct3[1:0])
            2'b00: begin size = 3'd1; size_mask = 4'b0001; end
            2'b01: begin size = 3'd2; size_mask = 4'b0011; end
            default: begin size = 3'd4; size_mask = 4'b1111; end
        endcase
        end_pos  = {1'b0, offset} + size;
        crossing = (end_pos > 3'd4);
        if (r_we)
            funct3_bad = !(r_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            funct3_bad = (r_funct3 inside {3'b011, 3'b110, 3'b111});
        illegal = funct3_bad || (crossing && !SPLIT_EN);
        // Low nibble covers the first word, high nibble spills into the next.
        span = {4'b0000, size_mask} << offset;
    end

    // Store data rotated so byte 0 of the request lands on lane 'offset'.
    assign wdata_pair = {r_wdata, r_wdata};
    assign rot_base   = 6'd32 - {1'b0, offset, 3'b000};
    assign wdata_rot  = wdata_pair[rot_base +: 32];

    // Load data: bring byte 'offset' of the captured pair down to byte 0.
    assign rdata_pair = {buf_hi, buf_lo};
    assign load_word  = rdata_pair[{offset, 3'b000} +: 32];

    // Truncate and sign/zero-extend the load result by funct3.
    always_comb begin
        load_ext = 32'h0;
        case (r_funct3)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b010:  load_ext = load_word;
            3'b100:  load_ext = {24'h0, load_word[7:0]};
            3'b101:  load_ext = {16'h0, load_word[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    // Memory-side and response outputs decoded from the current state.
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_DONE);
        rsp_err   = (state == S_DONE) && illegal;
        rsp_rdata = ((state == S_DONE) && !r_we && !illegal) ? load_ext : 32'h0;
        daddr     = 32'h0;
        dwdata    = 32'h0;
        dwe       = 4'b0000;
        case (state)
            S_ACC0: begin
                daddr  = word_addr;
                dwdata = wdata_rot;
                if (r_we && !illegal)
                    dwe = span[3:0];
            end
            S_ACC1: begin
                // Wraps modulo 2^32 at the top of the address space.
                daddr  = word_addr + 32'd4;
                dwdata = wdata_rot;
                if (r_we)
                    dwe = span[7:4];
            end
            default: ;
        endcase
    end

    // Sequencer: latch request, run one or two accesses, pulse response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            buf_lo   <= 32'h0;
            buf_hi   <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        state    <= S_ACC0;
                    end
                end
                S_ACC0: begin
                    buf_lo <= drdata;
                    state  <= (!illegal && crossing) ? S_ACC1 : S_DONE;
                end
                S_ACC1: begin
                    buf_hi <= drdata;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: scoreboard bench for lsu_align with a small word memory.
// A second instance with SPLIT_EN=0 sees the same requests.
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    logic        ns_req_ready;
    logic        ns_rsp_valid;
    logic [31:0] ns_rsp_rdata;
    logic        ns_rsp_err;
    logic [31:0] ns_daddr;
    logic [31:0] ns_dwdata;
    logic [3:0]  ns_dwe;
    logic [31:0] ns_drdata;

    lsu_align #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
    );

    lsu_align #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(ns_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
        .daddr(ns_daddr), .dwdata(ns_dwdata), .dwe(ns_dwe), .drdata(ns_drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory, 256 words, address bits [9:2]; written only by the main DUT.
    logic [31:0] mem [0:255];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (dwe[k]) mem[daddr[9:2]][8*k +: 8] <= dwdata[8*k +: 8];
        end
    end

    always_comb drdata    = mem[daddr[9:2]];
    always_comb ns_drdata = mem[ns_daddr[9:2]];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Access trace of the last request and the SPLIT_EN=0 observations.
    logic [31:0] tr_addr [2];
    logic [31:0] tr_data [2];
    logic [3:0]  tr_dwe  [2];
    int          n_acc;
    logic [3:0]  ns_dwe_acc;
    logic        ns_seen;
    logic [31:0] ns_rdata_obs;
    logic        ns_err_obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse pops one expected response.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_rdata"}, rsp_rdata, e.rdata);
                check({t, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
    end

    // Drive one request, push its expected response, trace the accesses and
    // measure cycles from the handshake cycle to rsp_valid.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat);
        bit seen;
        @(negedge clk);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back({exp_rdata, exp_err});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        n_acc      = 0;
        ns_dwe_acc = 4'b0000;
        ns_seen    = 1'b0;
        ns_rdata_obs = 32'h0;
        ns_err_obs   = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            ns_dwe_acc |= ns_dwe;
            if (ns_rsp_valid) begin
                ns_seen      = 1'b1;
                ns_rdata_obs = ns_rsp_rdata;
                ns_err_obs   = ns_rsp_err;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                check({tag, "_lat"}, k, exp_lat);
            end else if (n_acc < 2) begin
                tr_addr[n_acc] = daddr;
                tr_data[n_acc] = dwdata;
                tr_dwe[n_acc]  = dwe;
                n_acc++;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got 0x00000000, expected 0x00000001");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'h0, req_ready}, 32'd1);
        check("rst_valid",  {31'h0, rsp_valid}, 32'd0);
        check("rst_err",    {31'h0, rsp_err},   32'd0);
        check("rst_rdata",  rsp_rdata,          32'h0);
        check("rst_dwe",    {28'h0, dwe},       32'h0);
        check("rst_daddr",  daddr,              32'h0);
        check("rst_dwdata", dwdata,             32'h0);
        mem_clear = 1'b0;
        rst_n     = 1'b1;

        // Aligned word store: single access.
        do_req("sw100", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("sw100_nacc",  n_acc, 1);
        check("sw100_daddr", tr_addr[0], 32'h0000_0100);
        check("sw100_dwe",   {28'h0, tr_dwe[0]}, 32'hF);
        check("sw100_data",  tr_data[0], 32'hDEAD_BEEF);

        // Byte store on lane 1, then readback.
        do_req("sb101", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0077, 32'h0, 1'b0, 2);
        check("sb101_dwe", {28'h0, tr_dwe[0]}, 32'h2);
        do_req("lw100a", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_77EF, 1'b0, 2);

        // Preload the two-word window used for the crossing loads.
        do_req("sw200", 1'b1, 3'b010, 32'h0000_0200, 32'h4433_2211, 32'h0, 1'b0, 2);
        do_req("sw204", 1'b1, 3'b010, 32'h0000_0204, 32'h8877_6655, 32'h0, 1'b0, 2);

        do_req("lw203", 1'b0, 3'b010, 32'h0000_0203, 32'h0, 32'h7766_5544, 1'b0, 3);
        check("lw203_a0",   tr_addr[0], 32'h0000_0200);
        check("lw203_a1",   tr_addr[1], 32'h0000_0204);
        check("lw203_dwe",  {24'h0, tr_dwe[0], tr_dwe[1]}, 32'h0);
        do_req("lh203",  1'b0, 3'b001, 32'h0000_0203, 32'h0, 32'h0000_5544, 1'b0, 3);
        do_req("lb204",  1'b0, 3'b000, 32'h0000_0204, 32'h0, 32'h0000_0055, 1'b0, 2);
        do_req("lb207",  1'b0, 3'b000, 32'h0000_0207, 32'h0, 32'hFFFF_FF88, 1'b0, 2);
        do_req("lbu207", 1'b0, 3'b100, 32'h0000_0207, 32'h0, 32'h0000_0088, 1'b0, 2);
        do_req("lh206",  1'b0, 3'b001, 32'h0000_0206, 32'h0, 32'hFFFF_8877, 1'b0, 2);

        // Crossing half store and readback.
        do_req("sh1ff", 1'b1, 3'b001, 32'h0000_01FF, 32'h0000_CAFE, 32'h0, 1'b0, 3);
        check("sh1ff_a0",    tr_addr[0], 32'h0000_01FC);
        check("sh1ff_dwe0",  {28'h0, tr_dwe[0]}, 32'h8);
        check("sh1ff_lane3", {24'h0, tr_data[0][31:24]}, 32'hFE);
        check("sh1ff_a1",    tr_addr[1], 32'h0000_0200);
        check("sh1ff_dwe1",  {28'h0, tr_dwe[1]}, 32'h1);
        check("sh1ff_lane0", {24'h0, tr_data[1][7:0]}, 32'hCA);
        do_req("lhu1ff", 1'b0, 3'b101, 32'h0000_01FF, 32'h0, 32'h0000_CAFE, 1'b0, 3);

        // Crossing word store at the top of the address space.
        do_req("swtop", 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA5A5_1234, 32'h0, 1'b0, 3);
        check("swtop_a0",   tr_addr[0], 32'hFFFF_FFFC);
        check("swtop_dwe0", {28'h0, tr_dwe[0]}, 32'hC);
        check("swtop_a1",   tr_addr[1], 32'h0000_0000);
        check("swtop_dwe1", {28'h0, tr_dwe[1]}, 32'h3);
        check("swtop_ns_seen",  {31'h0, ns_seen},    32'd1);
        check("swtop_ns_dwe",   {28'h0, ns_dwe_acc}, 32'h0);
        check("swtop_ns_err",   {31'h0, ns_err_obs}, 32'd1);
        check("swtop_ns_rdata", ns_rdata_obs,        32'h0);
        do_req("lwzero", 1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0000_A5A5, 1'b0, 2);

        // Illegal funct3 codes.
        do_req("ld011", 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 2);
        check("ld011_dwe", {28'h0, tr_dwe[0]}, 32'h0);
        do_req("st100", 1'b1, 3'b100, 32'h0000_0100, 32'h1111_1111, 32'h0, 1'b1, 2);
        check("st100_dwe", {28'h0, tr_dwe[0]}, 32'h0);
        do_req("lw100b", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_77EF, 1'b0, 2);

        // Reset during ACC1 of a crossing store: no response, ACC0 bytes stay.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h0000_02FF;
        req_wdata  = 32'h0000_1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstacc_dwe0", {28'h0, dwe}, 32'h8);
        @(negedge clk);
        check("rstacc_dwe1", {28'h0, dwe}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstacc_dwe",   {28'h0, dwe},       32'h0);
        check("rstacc_ready", {31'h0, req_ready}, 32'd1);
        check("rstacc_valid", {31'h0, rsp_valid}, 32'd0);
        check("rstacc_daddr", daddr,              32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rstacc_hold_valid", {31'h0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req("lw2fc", 1'b0, 3'b010, 32'h0000_02FC, 32'h0, 32'h3400_0000, 1'b0, 2);
        do_req("lw300", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0000_0000, 1'b0, 2);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
